// File: rtl/ntt_seq_ctrl_pkg.sv
// Shared constants for the NTT load/transform/unload sequencer.
// Also holds the FSM state encoding and a FIFO-level helper.
package ntt_seq_ctrl_pkg;

    localparam int NTT_N   = 256;
    localparam int NTT_Q   = 8380417;
    localparam int NTT_AW  = 16;
    localparam int NTT_DW  = 24;
    localparam int NTT_TMO = 65535;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_KICK   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    function automatic logic [1:0] fifo_level(input logic full, input logic empty);
        return full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    endfunction

endpackage

// File: rtl/ntt_seq_ctrl_if.sv
// Command, coefficient stream, result stream, memory port-0 and NTT engine handshake.
// The slave modport is the sequencer; the master modport is its environment.
interface ntt_seq_ctrl_if
    import ntt_seq_ctrl_pkg::*;
#(
    parameter int AW = NTT_AW,
    parameter int DW = NTT_DW
);
    logic          cmd_start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          err_range;
    logic          err_tmo;
    logic          load_mem;
    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_D;
    logic          mem_WEB;
    logic [DW-1:0] mem_Q;
    logic          start_NTT;
    logic          done_NTT;

    modport master (
        output cmd_start, base_addr, in_valid, in_data, out_ready, mem_Q, done_NTT,
        input  in_ready, out_valid, out_data, busy, done, err_range, err_tmo,
               load_mem, mem_A, mem_D, mem_WEB, start_NTT
    );

    modport slave (
        input  cmd_start, base_addr, in_valid, in_data, out_ready, mem_Q, done_NTT,
        output in_ready, out_valid, out_data, busy, done, err_range, err_tmo,
               load_mem, mem_A, mem_D, mem_WEB, start_NTT
    );
endinterface

// File: rtl/ntt_out_fifo.sv
// Two-entry result FIFO; the head is always visible on pop_data.
// A pop is honoured only when not empty, a push at full only together with a pop.
module ntt_out_fifo #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every next-state value starts from its current value, so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset because the head drives out_data, which must read 0 in reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Sequencer: streams N coefficients into memory, kicks the NTT engine with a watchdog,
// then streams the transformed polynomial back out through a 2-entry FIFO.
module ntt_seq_ctrl
    import ntt_seq_ctrl_pkg::*;
#(
    parameter int N   = NTT_N,
    parameter int Q   = NTT_Q,
    parameter int AW  = NTT_AW,
    parameter int DW  = NTT_DW,
    parameter int TMO = NTT_TMO
) (
    input logic          clk,
    input logic          rst_n,
    ntt_seq_ctrl_if.slave bus
);

    localparam int CW = $clog2(N + 1);
    localparam int WW = $clog2(TMO + 1);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_d_q, mem_d_d;
    logic          mem_web_q, mem_web_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_range_q, err_range_d;
    logic          err_tmo_q, err_tmo_d;
    logic          rd_pend_q, rd_pend_d;

    logic          fifo_full, fifo_empty, fifo_pop;
    logic [1:0]    fifo_lvl;
    logic          in_fire, rd_issue;
    logic [DW-1:0] fifo_head;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign fifo_pop = bus.out_valid & bus.out_ready;
    assign fifo_lvl = fifo_level(fifo_full, fifo_empty);

    // A read may issue when the FIFO is guaranteed a free slot by the time its data returns,
    // counting a pop happening this same cycle; this keeps one word per cycle under full flow.
    assign rd_issue = (state_q == ST_UNLOAD) && (cnt_q != CW'(N)) &&
                      (({1'b0, fifo_lvl} + {2'b00, rd_pend_q}) <= (3'd1 + {2'b00, fifo_pop}));

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FIN);
    assign bus.in_ready  = (state_q == ST_LOAD) && (cnt_q < CW'(N));
    assign bus.start_NTT = (state_q == ST_KICK);
    assign bus.load_mem  = (state_q == ST_LOAD) || (state_q == ST_UNLOAD);
    assign bus.mem_A     = (state_q == ST_UNLOAD) ? (base_q + AW'(cnt_q)) : mem_a_q;
    assign bus.mem_D     = mem_d_q;
    assign bus.mem_WEB   = mem_web_q;
    assign bus.err_range = err_range_q;
    assign bus.err_tmo   = err_tmo_q;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = fifo_head;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        mem_a_d     = mem_a_q;
        mem_d_d     = mem_d_q;
        mem_web_d   = 1'b1;
        cnt_d       = cnt_q;
        out_cnt_d   = out_cnt_q;
        wdog_d      = wdog_q;
        err_range_d = err_range_q;
        err_tmo_d   = err_tmo_q;
        rd_pend_d   = rd_issue;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    base_d      = bus.base_addr;
                    err_range_d = 1'b0;
                    err_tmo_d   = 1'b0;
                    cnt_d       = '0;
                    out_cnt_d   = '0;
                    wdog_d      = '0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_fire) begin
                    mem_a_d   = base_q + AW'(cnt_q);
                    mem_d_d   = bus.in_data;
                    mem_web_d = 1'b0;
                    cnt_d     = cnt_q + CW'(1);
                    if (bus.in_data >= DW'(Q)) begin
                        err_range_d = 1'b1;
                    end
                end else if (cnt_q == CW'(N)) begin
                    // The last registered write is on the port during this cycle.
                    cnt_d   = '0;
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.done_NTT) begin
                    state_d = ST_UNLOAD;
                end else if (wdog_q == WW'(TMO - 1)) begin
                    err_tmo_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            ST_UNLOAD: begin
                if (rd_issue) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (fifo_pop) begin
                    out_cnt_d = out_cnt_q + CW'(1);
                    if (out_cnt_q == CW'(N - 1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            mem_a_q     <= '0;
            mem_d_q     <= '0;
            mem_web_q   <= 1'b1;
            cnt_q       <= '0;
            out_cnt_q   <= '0;
            wdog_q      <= '0;
            err_range_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            mem_a_q     <= mem_a_d;
            mem_d_q     <= mem_d_d;
            mem_web_q   <= mem_web_d;
            cnt_q       <= cnt_d;
            out_cnt_q   <= out_cnt_d;
            wdog_q      <= wdog_d;
            err_range_q <= err_range_d;
            err_tmo_q   <= err_tmo_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    ntt_out_fifo #(.DW(DW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_q),
        .push_data (bus.mem_Q),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
